// File: rtl/n1_pkg.sv
// Shared constants and types for the n1 memory subsystem.
package n1_pkg;

  localparam int ARB_PORTS  = 3;
  localparam int PORT_HOST  = 0;
  localparam int PORT_FETCH = 1;
  localparam int PORT_DATA  = 2;

  localparam int ADDR_BITS = 7;
  localparam int DATA_BITS = 16;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/n1_rr_pick2.sv
// Two-way round-robin picker between the fetch and data ports.
// The pointer names the preferred requester and flips to the other one after either is taken.
module n1_rr_pick2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] take,
  output logic [1:0] gnt
);

  logic ptr;  // 0: req[0] preferred, 1: req[1] preferred

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!ptr || !req[1])) gnt = 2'b01;
    else if (req[1])                 gnt = 2'b10;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       ptr <= 1'b0;
    else if (take[0]) ptr <= 1'b1;
    else if (take[1]) ptr <= 1'b0;
  end

endmodule

// File: rtl/n1_mem_arbiter.sv
// Single-port RAM arbiter for host loader, instruction fetch and data ports, with lock and timeout.
// N1_ARB_RR_EN selects round-robin between fetch and data; otherwise data has fixed priority.
module n1_mem_arbiter #(
  parameter int ADDR_BITS = 7,
  parameter int DATA_BITS = 16,
  parameter int LOCK_MAX  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 p0_valid,
  output logic                 p0_ready,
  input  logic                 p0_we,
  input  logic                 p0_lock,
  input  logic [ADDR_BITS-1:0] p0_addr,
  input  logic [DATA_BITS-1:0] p0_wdata,
  output logic                 p0_rsp_valid,
  input  logic                 p1_valid,
  output logic                 p1_ready,
  input  logic                 p1_we,
  input  logic                 p1_lock,
  input  logic [ADDR_BITS-1:0] p1_addr,
  input  logic [DATA_BITS-1:0] p1_wdata,
  output logic                 p1_rsp_valid,
  input  logic                 p2_valid,
  output logic                 p2_ready,
  input  logic                 p2_we,
  input  logic                 p2_lock,
  input  logic [ADDR_BITS-1:0] p2_addr,
  input  logic [DATA_BITS-1:0] p2_wdata,
  output logic                 p2_rsp_valid,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0] ram_wdata,
  input  logic [DATA_BITS-1:0] ram_rdata
);
  import n1_pkg::*;

  localparam int CNT_BITS = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(LOCK_MAX - 1);

  logic [ARB_PORTS-1:0] valid, we, lock, gnt, rsp_q;
  logic [ADDR_BITS-1:0] addr  [ARB_PORTS];
  logic [DATA_BITS-1:0] wdata [ARB_PORTS];
  logic [1:0]           pick, sel;
  logic [1:0]           owner, owner_nxt;
  logic [CNT_BITS-1:0]  cnt, cnt_nxt;
  arb_state_t           state, state_nxt;

  assign valid = {p2_valid, p1_valid, p0_valid};
  assign we    = {p2_we, p1_we, p0_we};
  assign lock  = {p2_lock, p1_lock, p0_lock};
  assign addr[PORT_HOST]   = p0_addr;
  assign addr[PORT_FETCH]  = p1_addr;
  assign addr[PORT_DATA]   = p2_addr;
  assign wdata[PORT_HOST]  = p0_wdata;
  assign wdata[PORT_FETCH] = p1_wdata;
  assign wdata[PORT_DATA]  = p2_wdata;

`ifdef N1_ARB_RR_EN
  n1_rr_pick2 u_rr (
    .clk  (clk),
    .rst_n(rst_n),
    .req  ({p2_valid, p1_valid}),
    .take (gnt[PORT_DATA:PORT_FETCH]),
    .gnt  (pick)
  );
`else
  assign pick = p2_valid ? 2'b10 : {1'b0, p1_valid};
`endif

  // A held lock shuts out everyone but the owner, including the host port.
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (state == LOCKED)           gnt[owner] = valid[owner];
      else if (valid[PORT_HOST])     gnt[PORT_HOST] = 1'b1;
      else                           gnt[PORT_DATA:PORT_FETCH] = pick;
    end
  end

  always_comb begin
    sel = 2'(PORT_HOST);
    if (gnt[PORT_FETCH]) sel = 2'(PORT_FETCH);
    if (gnt[PORT_DATA])  sel = 2'(PORT_DATA);
  end

  // Lock FSM: state | meaning
  //   UNLOCKED | normal priority arbitration
  //   LOCKED   | only `owner` may be granted; cnt counts idle cycles toward LOCK_MAX
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    case (state)
      UNLOCKED: begin
        if (|(gnt & lock)) begin
          state_nxt = LOCKED;
          owner_nxt = sel;
          cnt_nxt   = '0;
        end
      end
      LOCKED: begin
        if (gnt[owner]) begin
          cnt_nxt = '0;
          if (!lock[owner]) state_nxt = UNLOCKED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = UNLOCKED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= UNLOCKED;
      owner <= '0;
      cnt   <= '0;
      rsp_q <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      rsp_q <= gnt & ~we;
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    for (int i = 0; i < ARB_PORTS; i++) begin
      if (gnt[i]) begin
        ram_addr  = addr[i];
        ram_wdata = wdata[i];
      end
    end
  end

  assign ram_en = |gnt;
  assign ram_we = |(gnt & we);

  assign p0_ready = gnt[PORT_HOST];
  assign p1_ready = gnt[PORT_FETCH];
  assign p2_ready = gnt[PORT_DATA];

  // Gated by rst_n so a read in flight when reset asserts never shows a response.
  assign p0_rsp_valid = rsp_q[PORT_HOST] & rst_n;
  assign p1_rsp_valid = rsp_q[PORT_FETCH] & rst_n;
  assign p2_rsp_valid = rsp_q[PORT_DATA] & rst_n;
  assign rsp_rdata    = ram_rdata;

endmodule

// File: tb/tb_n1_mem_arbiter.sv
// Directed bench for n1_mem_arbiter: vector table for arbitration plus lock, timeout, reset and read-return sequences.
module tb_n1_mem_arbiter;

`ifdef N1_ARB_RR_EN
  localparam bit RR_ON = 1'b1;
`else
  localparam bit RR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_valid, p0_we, p0_lock, p1_valid, p1_we, p1_lock, p2_valid, p2_we, p2_lock;
  logic [6:0]  p0_addr, p1_addr, p2_addr;
  logic [15:0] p0_wdata, p1_wdata, p2_wdata;
  logic        p0_ready, p1_ready, p2_ready;
  logic        p0_rsp_valid, p1_rsp_valid, p2_rsp_valid;
  logic [15:0] rsp_rdata, ram_wdata, ram_rdata;
  logic        ram_en, ram_we;
  logic [6:0]  ram_addr;
  logic [15:0] mem [128];

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  n1_mem_arbiter #(.ADDR_BITS(7), .DATA_BITS(16), .LOCK_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_lock(p0_lock),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_lock(p1_lock),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p2_valid(p2_valid), .p2_ready(p2_ready), .p2_we(p2_we), .p2_lock(p2_lock),
    .p2_addr(p2_addr), .p2_wdata(p2_wdata), .p2_rsp_valid(p2_rsp_valid),
    .rsp_rdata(rsp_rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous RAM; addresses 1 and 2 are loaded while reset is held.
  always @(posedge clk) begin
    if (!rst_n) begin
      mem[1] <= 16'h0011;
      mem[2] <= 16'h0022;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  wire [2:0] rdy = {p2_ready, p1_ready, p0_ready};
  wire [2:0] rsp = {p2_rsp_valid, p1_rsp_valid, p0_rsp_valid};

  typedef struct packed {
    logic [2:0] valid;
    logic [2:0] we;
    logic [2:0] exp_rr;
    logic [2:0] exp_fx;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] w, input logic [2:0] l);
    {p2_valid, p1_valid, p0_valid} = v;
    {p2_we, p1_we, p0_we}          = w;
    {p2_lock, p1_lock, p0_lock}    = l;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] addr_of(input logic [2:0] g);
    case (g)
      3'b001:  return 7'd10;
      3'b010:  return 7'd11;
      3'b100:  return 7'd12;
      default: return 7'd0;
    endcase
  endfunction

  initial begin
    logic [2:0] exp_rdy, prev_rsp;
    int idle;

    // valid, we, expected ready with round-robin, expected ready with fixed P2>P1 ({p2,p1,p0})
    vecs[0]  = {3'b000, 3'b000, 3'b000, 3'b000};
    vecs[1]  = {3'b110, 3'b000, 3'b010, 3'b100};
    vecs[2]  = {3'b110, 3'b100, 3'b100, 3'b100};
    vecs[3]  = {3'b110, 3'b000, 3'b010, 3'b100};
    vecs[4]  = {3'b111, 3'b001, 3'b001, 3'b001};
    vecs[5]  = {3'b010, 3'b000, 3'b010, 3'b010};
    vecs[6]  = {3'b110, 3'b010, 3'b100, 3'b100};
    vecs[7]  = {3'b100, 3'b000, 3'b100, 3'b100};
    vecs[8]  = {3'b110, 3'b000, 3'b010, 3'b100};
    vecs[9]  = {3'b011, 3'b001, 3'b001, 3'b001};
    vecs[10] = {3'b000, 3'b000, 3'b000, 3'b000};

    rst_n = 1'b0;
    drive(3'b111, 3'b000, 3'b000);
    p0_addr = 7'd10; p1_addr = 7'd11; p2_addr = 7'd12;
    p0_wdata = 16'h0; p1_wdata = 16'h0; p2_wdata = 16'h0;

    @(negedge clk);
    chk("reset_ready", 32'(rdy), 32'd0);
    chk("reset_ram_en", 32'(ram_en), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    drive(3'b000, 3'b000, 3'b000);
    @(negedge clk);
    chk("idle_rsp", 32'(rsp), 32'd0);
    chk("idle_ram", 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'd0);
    next_cycle();

    prev_rsp = 3'b000;
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].valid, vecs[i].we, 3'b000);
      p0_wdata = 16'h1000 + 16'(i);
      p1_wdata = 16'h2000 + 16'(i);
      p2_wdata = 16'h3000 + 16'(i);
      exp_rdy = RR_ON ? vecs[i].exp_rr : vecs[i].exp_fx;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 32'(rdy), 32'(exp_rdy));
      chk($sformatf("vec%0d_ram_en", i), 32'(ram_en), 32'(|exp_rdy));
      chk($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(addr_of(exp_rdy)));
      chk($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(|(exp_rdy & vecs[i].we)));
      chk($sformatf("vec%0d_rsp", i), 32'(rsp), 32'(prev_rsp));
      prev_rsp = exp_rdy & ~vecs[i].we;
      next_cycle();
    end

    // Host write to 5, then fetch read of 5 returns the written word.
    drive(3'b011, 3'b001, 3'b000);
    p0_addr = 7'd5; p0_wdata = 16'hBEEF; p1_addr = 7'd5;
    @(negedge clk);
    chk("beef_wr_ready", 32'(rdy), 32'b001);
    next_cycle();
    drive(3'b010, 3'b000, 3'b000);
    @(negedge clk);
    chk("beef_rd_ready", 32'(rdy), 32'b010);
    chk("beef_rd_addr", 32'(ram_addr), 32'd5);
    next_cycle();
    drive(3'b000, 3'b000, 3'b000);
    @(negedge clk);
    chk("beef_rsp", 32'(rsp), 32'b010);
    chk("beef_rdata", 32'(rsp_rdata), 32'hBEEF);
    next_cycle();

    // Data port locked read-modify-write of address 3 keeps host and fetch out.
    drive(3'b100, 3'b000, 3'b100);
    p2_addr = 7'd3; p0_addr = 7'd20; p1_addr = 7'd21;
    @(negedge clk);
    chk("rmw_rd_ready", 32'(rdy), 32'b100);
    next_cycle();
    drive(3'b011, 3'b000, 3'b000);
    @(negedge clk);
    chk("rmw_locked_ready", 32'(rdy), 32'b000);
    chk("rmw_rsp", 32'(rsp), 32'b100);
    next_cycle();
    drive(3'b111, 3'b100, 3'b000);
    p2_wdata = 16'h5A5A;
    @(negedge clk);
    chk("rmw_wr_ready", 32'(rdy), 32'b100);
    next_cycle();
    drive(3'b011, 3'b000, 3'b000);
    @(negedge clk);
    chk("rmw_release_ready", 32'(rdy), 32'b001);
    next_cycle();

    // Fetch takes a lock and abandons it; a renewal at the timeout cycle wins, then the lock times out.
    drive(3'b010, 3'b000, 3'b010);
    @(negedge clk);
    chk("to_lock_ready", 32'(rdy), 32'b010);
    next_cycle();
    drive(3'b001, 3'b000, 3'b000);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("to_hold%0d_ready", k), 32'(rdy), 32'b000);
      next_cycle();
    end
    drive(3'b011, 3'b000, 3'b010);
    @(negedge clk);
    chk("to_renew_ready", 32'(rdy), 32'b010);
    next_cycle();
    drive(3'b001, 3'b000, 3'b000);
    idle = 0;
    @(negedge clk);
    while (!p0_ready && idle < 20) begin
      idle++;
      next_cycle();
      @(negedge clk);
    end
    chk("to_idle_cycles", 32'(idle), 32'd8);
    chk("to_host_granted", 32'(p0_ready), 32'd1);
    next_cycle();

    // Reset right after a fetch read is accepted drops its response.
    drive(3'b010, 3'b000, 3'b000);
    p1_addr = 7'd1;
    @(negedge clk);
    chk("rst_rd_ready", 32'(rdy), 32'b010);
    next_cycle();
    rst_n = 1'b0;
    drive(3'b111, 3'b000, 3'b000);
    @(negedge clk);
    chk("rst_rsp", 32'(rsp), 32'b000);
    chk("rst_ready", 32'(rdy), 32'b000);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("rst_ready2", 32'(rdy), 32'b000);
    next_cycle();
    rst_n = 1'b1;
    drive(3'b110, 3'b000, 3'b000);
    p1_addr = 7'd1; p2_addr = 7'd2;
    @(negedge clk);
    chk("post_rst_tie", 32'(rdy), RR_ON ? 32'b010 : 32'b100);
    chk("post_rst_rsp", 32'(rsp), 32'b000);
    next_cycle();

    // Alternating fetch/data reads of the preloaded words, one accept per cycle.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive((i % 2 == 0) ? 3'b010 : 3'b100, 3'b000, 3'b000);
      else       drive(3'b000, 3'b000, 3'b000);
      @(negedge clk);
      if (i < 4) chk($sformatf("alt%0d_ready", i), 32'(rdy), (i % 2 == 0) ? 32'b010 : 32'b100);
      if (i > 0) begin
        chk($sformatf("alt%0d_rsp", i), 32'(rsp), (i % 2 == 1) ? 32'b010 : 32'b100);
        chk($sformatf("alt%0d_rdata", i), 32'(rsp_rdata), (i % 2 == 1) ? 32'h0011 : 32'h0022);
      end
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
